// File: rtl/normalizer32.sv
// Multi-cycle normalizer: binary-search leading/trailing zero count (16,8,4,2,1)
// and the matching normalized value, one stage per clock.
module normalizer32 #(
    parameter int unsigned ZERO_COUNT = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [31:0] operand,
    input  logic        leftNotRight,
    output logic [31:0] result,
    output logic [31:0] shift,
    output logic        zero,
    output logic        busy,
    output logic        done
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 6;
    localparam int unsigned KW = 3;

    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    state_t          state, state_d;
    logic [DW-1:0]   work, work_d;
    logic [CW-1:0]   count, count_d;
    logic [KW-1:0]   k, k_d;
    logic            dir, dir_d;
    logic [DW-1:0]   result_d, shift_d;
    logic            zero_d, busy_d, done_d;

    logic [CW-1:0]   step;
    logic [DW-1:0]   left_mask, right_mask;
    logic            stage_hit;
    logic [DW-1:0]   stage_work;
    logic [CW-1:0]   stage_count;

    // One binary-search stage on the current working value.
    always_comb begin
        step        = CW'(CW'(1) << k);
        left_mask   = ~({DW{1'b1}} >> step);
        right_mask  = ~({DW{1'b1}} << step);
        stage_hit   = dir ? ((work & left_mask) == '0) : ((work & right_mask) == '0);
        stage_work  = work;
        stage_count = count;
        if (stage_hit) begin
            stage_work  = dir ? (work << step) : (work >> step);
            stage_count = CW'(count + step);
        end
    end

    always_comb begin
        state_d  = state;
        work_d   = work;
        count_d  = count;
        k_d      = k;
        dir_d    = dir;
        result_d = result;
        shift_d  = shift;
        zero_d   = zero;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    work_d  = operand;
                    dir_d   = leftNotRight;
                    count_d = '0;
                    k_d     = KW'(4);
                    busy_d  = 1'b1;
                    state_d = STEP;
                end
            end
            STEP: begin
                work_d  = stage_work;
                count_d = stage_count;
                if (k == '0) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = stage_work;
                    zero_d   = (stage_work == '0);
                    // A zero operand saturates the count at 31; report the dedicated code instead.
                    shift_d  = (stage_work == '0) ? DW'(ZERO_COUNT) : DW'(stage_count);
                end else begin
                    k_d    = KW'(k - KW'(1));
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            work   <= '0;
            count  <= '0;
            k      <= '0;
            dir    <= 1'b0;
            result <= '0;
            shift  <= '0;
            zero   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            work   <= work_d;
            count  <= count_d;
            k      <= k_d;
            dir    <= dir_d;
            result <= result_d;
            shift  <= shift_d;
            zero   <= zero_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

endmodule

// File: tb/tb_normalizer32.sv
// Scoreboard bench for normalizer32: directed test-plan cases, reset abort and
// 1000 random nonzero operands with a barrel-shifter round-trip check.
module tb_normalizer32;

    localparam int unsigned ZC = 32;

    logic        CLK, RST, start, leftNotRight;
    logic [31:0] operand, result, shift;
    logic        zero, busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] op;
        logic        left;
        logic [31:0] res;
        logic [31:0] sh;
        logic        z;
    } exp_t;

    exp_t sb[$];

    normalizer32 #(.ZERO_COUNT(ZC)) dut (
        .CLK(CLK), .RST(RST), .start(start), .operand(operand),
        .leftNotRight(leftNotRight), .result(result), .shift(shift),
        .zero(zero), .busy(busy), .done(done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] op, input logic l, input logic [31:0] res,
                                input logic [31:0] sh, input logic z);
        exp_t e;
        e.op = op; e.left = l; e.res = res; e.sh = sh; e.z = z;
        return e;
    endfunction

    // Reference: linear scan for the first set bit.
    function automatic exp_t model(input logic [31:0] op, input logic l);
        int n = 0;
        if (op == 0) return mk(op, l, 32'h0, ZC, 1'b1);
        if (l) while (!op[31-n]) n++;
        else   while (!op[n]) n++;
        return mk(op, l, l ? (op << n) : (op >> n), 32'(n), 1'b0);
    endfunction

    function automatic logic [31:0] barrel(input logic [31:0] v, input logic [31:0] amt, input logic l);
        return l ? (v << amt) : (v >> amt);
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest pending operation.
    always @(negedge CLK) begin
        if (!RST && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("shift", shift, e.sh);
                check("zero", 32'(zero), 32'(e.z));
                if (!e.z) begin
                    check("norm_bit", 32'(e.left ? result[31] : result[0]), 32'h1);
                    check("round_trip", barrel(result, shift, !e.left), e.op);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] op, input logic l, input exp_t e);
        int g = 0;
        while (busy && g < 50) begin @(posedge CLK); #1; g++; end
        if (busy) check("issue_timeout", 32'(busy), 32'h0);
        operand = op; leftNotRight = l; start = 1'b1;
        sb.push_back(e);
        @(posedge CLK); #1;
        start = 1'b0; operand = $urandom; leftNotRight = 1'($urandom);
    endtask

    // Called at E0+1: busy for five cycles, done in the sixth.
    task automatic check_timing(input string tag);
        for (int i = 0; i < 5; i++) begin
            check({tag, "_busy"}, 32'(busy), 32'h1);
            check({tag, "_nodone"}, 32'(done), 32'h0);
            @(posedge CLK); #1;
        end
        check({tag, "_done"}, 32'(done), 32'h1);
        check({tag, "_idle"}, 32'(busy), 32'h0);
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done && g < 20) begin @(posedge CLK); #1; g++; end
        if (!done) check("done_timeout", 32'(done), 32'h1);
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 100) begin @(posedge CLK); #1; g++; end
        check("drain", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; operand = '0; leftNotRight = 1'b0;
        #12;
        check("rst_result", result, 32'h0);
        check("rst_shift", shift, 32'h0);
        check("rst_zero", 32'(zero), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        @(posedge CLK); #1; RST = 1'b0;
        @(posedge CLK); #1;

        issue(32'h0000_0001, 1'b1, mk(32'h0000_0001, 1'b1, 32'h8000_0000, 32'd31, 1'b0));
        check_timing("lsb_left");
        @(posedge CLK); #1;

        // Back-to-back: second start issued in the DONE cycle of the first.
        issue(32'h8000_0000, 1'b1, mk(32'h8000_0000, 1'b1, 32'h8000_0000, 32'd0, 1'b0));
        wait_done();
        issue(32'h0001_2340, 1'b0, mk(32'h0001_2340, 1'b0, 32'h0000_048D, 32'd6, 1'b0));
        check_timing("b2b");
        drain();

        issue(32'h0, 1'b1, mk(32'h0, 1'b1, 32'h0, 32'd32, 1'b1));
        check_timing("zero_left");
        issue(32'h0, 1'b0, mk(32'h0, 1'b0, 32'h0, 32'd32, 1'b1));
        check_timing("zero_right");
        drain();

        // Start while busy must be ignored.
        issue(32'hFFFF_FFFF, 1'b1, mk(32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0));
        @(posedge CLK); #1;
        operand = 32'h0000_0005; leftNotRight = 1'b0; start = 1'b1;
        @(posedge CLK); #1; start = 1'b0;
        wait_done();
        repeat (10) @(posedge CLK);
        #1;
        drain();

        issue(32'h00F0_0000, 1'b1, mk(32'h00F0_0000, 1'b1, 32'hF000_0000, 32'd8, 1'b0));
        check_timing("round_trip_dir");
        drain();

        // Reset mid-operation: aborted op is not scoreboarded, so any done is spurious.
        operand = 32'h0000_0100; leftNotRight = 1'b1; start = 1'b1;
        @(posedge CLK); #1; start = 1'b0;
        @(posedge CLK); #1; @(posedge CLK); #1;
        RST = 1'b1;
        #1;
        check("abort_result", result, 32'h0);
        check("abort_shift", shift, 32'h0);
        check("abort_zero", 32'(zero), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        @(posedge CLK); #1; RST = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        check("abort_still_idle", 32'(busy), 32'h0);

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] op;
            logic l;
            l = 1'($urandom);
            op = l ? ($urandom >> $urandom_range(0, 31)) : ($urandom << $urandom_range(0, 31));
            if (op == 0) op = 32'h1 << $urandom_range(0, 31);
            issue(op, l, model(op, l));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/normalizer32.md
Name: normalizer32

Overview:
- Multi-cycle normalizer, the inverse of barrel_shifter: given an operand, it finds the shift amount that moves the first set bit to the edge, and produces the normalized value.
- Left mode: counts leading zeros and shifts left until bit31=1. Right mode: counts trailing zeros and shifts right until bit0=1.
- Works as a binary search, one stage per cycle (16, 8, 4, 2, 1). Sits beside barrel_shifter in the ALU/FPU datapath.
- Contract: feeding {result, shift} back into barrel_shifter with the opposite direction recovers the operand exactly.

Parameters:
ZERO_COUNT, 32, value reported on shift when operand is zero.

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  asynchronous, active-high reset
start  input  1  request; sampled on rising CLK when busy=0
operand  input  32  value to normalize; captured with start
leftNotRight  input  1  1 = normalize toward MSB (leading zeros); 0 = toward LSB (trailing zeros); captured with start
result  output  32  normalized value, registered
shift  output  32  shift amount, 0..31 or ZERO_COUNT; bits [31:6] always 0
zero  output  1  operand was all zeros
busy  output  1  operation in progress
done  output  1  one-cycle pulse when result/shift/zero become valid

Behaviour:
- Reset (RST=1, asynchronous): state=IDLE; result, shift, zero, busy, done all 0; internal working register and count 0.
- States: IDLE, STEP, DONE. Stage index k in {4,3,2,1,0}.
- IDLE:
  - start=1 at edge E0: capture operand into work, capture leftNotRight, count=0, k=4, go to STEP.
  - start=0: stay in IDLE.
- STEP, one stage per edge (E1..E5), step size s=2^k:
  - Left: if work[31:32-s]==0 then work<=work<<s and count<=count+s.
  - Right: if work[s-1:0]==0 then work<=work>>s and count<=count+s.
  - Zeros are shifted in; no sign extension; no rotation.
  - k decrements each edge. At E5 (k=0) go to DONE and register outputs:
    - result<=work (after the final stage);
    - shift<=count, or ZERO_COUNT if work is all zero;
    - zero<=(work==0);
    - done<=1.
- DONE lasts exactly one cycle: done=1, busy=0. The next edge clears done.
  - start=1 in DONE: accepted as in IDLE (back-to-back).
  - Otherwise return to IDLE.
- Latency: start seen at E0 → done high in the cycle after E5. Issue rate: one operation per 6 cycles.
- busy=1 exactly while state==STEP (cycles E0..E5).
- start while busy: ignored, with no effect on the in-flight operation. operand and leftNotRight may change freely after E0.
- result, shift and zero hold their last values until the next DONE. They do not change during STEP.
- Zero operand: all stages fire, so count reaches 31 internally. Outputs are forced to result=0, shift=ZERO_COUNT, zero=1. Latency is unchanged.
- Already-normalized operand (bit31=1 in left mode, bit0=1 in right mode): shift=0, result=operand.
- RST mid-operation: immediate abort. No done is pulsed for the aborted operation, and outputs return to reset values.

Test Plan:
- operand=0x0000_0001, left → result=0x8000_0000, shift=31, zero=0; busy high for 5 cycles; done pulses in the 6th cycle after start.
- operand=0x8000_0000 left, then operand=0x0001_2340 right (start in the DONE cycle) → first: result=0x8000_0000, shift=0. Second: result=0x0000_048D, shift=6, with no idle gap.
- operand=0x0000_0000, both modes → result=0, shift=32, zero=1, same latency.
- start issued 2 cycles into an operation with operand=0xFFFF_FFFF; RST=1 asserted mid-run of a later operation → first operation completes with its original values and the second start is ignored; after RST all outputs are 0, busy=0, and no done appears.
- Round trip with operand=0x00F0_0000, left → result=0xF000_0000, shift=8. barrel_shifter(result, shift, leftNotRight=0) returns 0x00F0_0000.
- Randomized 1000 nonzero operands, both modes → result MSB (or LSB)=1, shift equals reference clz/ctz, round trip through barrel_shifter exact.
